// File: rtl/contador_regressivo_pkg.sv
// contador_regressivo_pkg: state encodings and sizing helper shared by the timer and its controller
package contador_regressivo_pkg;
  typedef enum logic [1:0] {
    ST_OCIOSO   = 2'd0,
    ST_CONTANDO = 2'd1,
    ST_FIM      = 2'd2
  } estado_t;
  function automatic int pre_width(input int div);
    return div > 1 ? $clog2(div) : 1;
  endfunction
endpackage

// File: rtl/contador_regressivo_if.sv
// contador_regressivo_if: load/pause controls and count/status outputs of the down-counter
interface contador_regressivo_if #(parameter int WIDTH = 4);
  logic             start;
  logic             pause;
  logic [WIDTH-1:0] valor;
  logic [WIDTH-1:0] q;
  logic             ocupado;
  logic             fim;
  modport master (output start, pause, valor, input q, ocupado, fim);
  modport slave  (input start, pause, valor, output q, ocupado, fim);
endinterface

// File: rtl/contador_regressivo_divisor_tick.sv
// divisor_tick: prescaler producing one tick every DIV un-held clocks
module divisor_tick
  import contador_regressivo_pkg::*;
#(
  parameter int DIV = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic hold,
  output logic tick
);
  localparam int PW = pre_width(DIV);
  logic [PW-1:0] pre;
  assign tick = !hold && pre == PW'(DIV - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) pre <= '0;
    else if (clr) pre <= '0;
    else if (!hold) pre <= tick ? '0 : pre + PW'(1);
endmodule

// File: rtl/contador_regressivo.sv
// contador_regressivo: loadable down-counter timer with one-cycle fim pulse at terminal count
module contador_regressivo
  import contador_regressivo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DIV   = 3
) (
  input logic                  clk,
  input logic                  reset,
  contador_regressivo_if.slave bus
);
  estado_t          state, next;
  logic [WIDTH-1:0] q;
  logic             load, tick, counting;
  assign counting = state == ST_CONTANDO;
  // the unused encoding never loads; it just falls back to OCIOSO
  assign load = bus.start && state inside {ST_OCIOSO, ST_CONTANDO, ST_FIM};
  divisor_tick #(.DIV(DIV)) u_div (
    .clk  (clk),
    .reset(reset),
    .clr  (load),
    .hold (bus.pause || !counting),
    .tick (tick)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= ST_OCIOSO;
    else state <= next;
  always_comb begin
    next = ST_OCIOSO;
    if (load) next = bus.valor == '0 ? ST_FIM : ST_CONTANDO;
    else if (counting) next = tick && q == WIDTH'(1) ? ST_FIM : ST_CONTANDO;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (load) q <= bus.valor;
    else if (counting && tick) q <= q - WIDTH'(1);
  always_comb begin
    bus.q       = q;
    bus.ocupado = counting;
    bus.fim     = state == ST_FIM;
  end
endmodule

// File: tb/tb_contador_regressivo.sv
// tb_contador_regressivo: scoreboard bench driving a DIV=3 and a DIV=1 timer with shared stimulus
module tb_contador_regressivo;
  typedef struct {
    integer q3, o3, f3, q1, o1, f1;
  } exp_t;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  contador_regressivo_if #(.WIDTH(4)) b3 ();
  contador_regressivo_if #(.WIDTH(4)) b1 ();
  contador_regressivo #(.WIDTH(4), .DIV(3)) u_d3 (.clk(clk), .reset(reset), .bus(b3));
  contador_regressivo #(.WIDTH(4), .DIV(1)) u_d1 (.clk(clk), .reset(reset), .bus(b1));
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int divs[2] = '{3, 1};
  int cnt[2], el[2], busy[2], done[2];
  task automatic chk(input string n, input integer a, input integer e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", n, a, e);
    end
  endtask
  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      cnt[k] = 0; el[k] = 0; busy[k] = 0; done[k] = 0;
    end
  endfunction
  // timer behaviour in terms of remaining count and cycles since the last decrement
  function automatic void model_step(input int k, input bit s, input bit p, input int v);
    if (s) begin
      cnt[k] = v; el[k] = 0; busy[k] = int'(v != 0); done[k] = int'(v == 0);
    end else if (busy[k] != 0) begin
      done[k] = 0;
      if (!p) begin
        el[k]++;
        if (el[k] == divs[k]) begin
          el[k] = 0;
          cnt[k]--;
          if (cnt[k] == 0) begin busy[k] = 0; done[k] = 1; end
        end
      end
    end else done[k] = 0;
  endfunction
  task automatic drive(input bit s, input bit p, input int v);
    b3.start = s; b3.pause = p; b3.valor = 4'(v);
    b1.start = s; b1.pause = p; b1.valor = 4'(v);
  endtask
  task automatic cyc(input bit s, input bit p, input int v);
    @(negedge clk);
    drive(s, p, v);
    for (int k = 0; k < 2; k++) model_step(k, s, p, v);
    sb.push_back('{cnt[0], busy[0], done[0], cnt[1], busy[1], done[1]});
  endtask
  task automatic chk_idle(input string n);
    chk({n, "_q3"}, b3.q, 0);
    chk({n, "_ocupado3"}, b3.ocupado, 0);
    chk({n, "_fim3"}, b3.fim, 0);
    chk({n, "_q1"}, b1.q, 0);
    chk({n, "_ocupado1"}, b1.ocupado, 0);
    chk({n, "_fim1"}, b1.fim, 0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("q3", b3.q, e.q3);
        chk("ocupado3", b3.ocupado, e.o3);
        chk("fim3", b3.fim, e.f3);
        chk("q1", b1.q, e.q1);
        chk("ocupado1", b1.ocupado, e.o1);
        chk("fim1", b1.fim, e.f1);
      end
    end
  end
  initial begin
    drive(0, 0, 0);
    model_reset();
    #1 reset = 0;
    repeat (2) @(posedge clk);
    #2 chk_idle("reset");
    @(negedge clk) reset = 1;
    repeat (2) cyc(0, 0, 0);
    cyc(1, 0, 5);
    repeat (20) cyc(0, 0, 0);
    cyc(1, 0, 4);
    repeat (2) cyc(0, 0, 0);
    repeat (3) cyc(0, 1, 0);
    repeat (20) cyc(0, 0, 0);
    cyc(1, 0, 5);
    repeat (2) cyc(0, 0, 0);
    cyc(1, 1, 9);
    repeat (3) cyc(0, 1, 0);
    repeat (35) cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 2);
    repeat (10) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (3) cyc(0, 0, 0);
    cyc(1, 0, 15);
    repeat (50) cyc(0, 0, 0);
    repeat (400) cyc($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15));
    repeat (50) cyc(0, 0, 0);
    cyc(1, 0, 7);
    cyc(0, 0, 0);
    @(posedge clk);
    #2 chk("prereset_q3", b3.q, 7);
    reset = 0;
    #1 chk_idle("async_reset");
    model_reset();
    @(negedge clk) drive(1, 0, 5);
    @(posedge clk);
    #1 chk_idle("held_reset");
    @(negedge clk) begin
      drive(0, 0, 0);
      reset = 1;
    end
    repeat (3) cyc(0, 0, 0);
    repeat (3) @(posedge clk);
    #2 chk("drain", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
